// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_FULL,
    S_DROP
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & INSTR_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Request/grant/response instruction-memory port with one outstanding request.
interface fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_buf.sv
// Single-entry holding register for an instruction that arrived while decode was stalled.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  // Clear wins over load so a redirect can never leave a stale entry behind
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one memory request at a time and
// hands one instruction per delivery to the decode register, or a NOP bubble.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_f_i,
  input  logic        pc_src_e_i,
  input  logic [31:0] pc_target_e_i,
  fetch_if.master     imem,
  output logic [31:0] rd_f_o,
  output logic [31:0] pc_f_o,
  output logic [31:0] pc_plus4_f_o,
  output logic        fetch_valid_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fpc_q, fpc_d;
  logic [31:0]  req_pc_q, req_pc_d;

  logic         memReq;
  logic         bufLoad, bufClear, bufValid;
  logic [31:0]  bufInstr, bufPc;
  logic         outValid;
  logic [31:0]  outInstr, outPc;
  logic [31:0]  redirectPc;

  assign redirectPc = align_pc(pc_target_e_i);

  fetch_buf u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (bufLoad),
    .clear_i (bufClear),
    .instr_i (imem.imem_rdata),
    .pc_i    (req_pc_q),
    .valid_o (bufValid),
    .instr_o (bufInstr),
    .pc_o    (bufPc)
  );

  // FSM state, next-request PC and in-flight PC registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_REQ;
      fpc_q    <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Next-state logic; a redirect overrides stall and the normal flow in every state
  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    req_pc_d = req_pc_q;
    memReq   = 1'b0;
    bufLoad  = 1'b0;
    bufClear = 1'b0;
    outValid = 1'b0;
    outInstr = NOP_INSTR;
    outPc    = 32'h0;

    unique case (state_q)
      S_REQ: begin
        memReq = 1'b1;
        if (pc_src_e_i) begin
          fpc_d    = redirectPc;
          bufClear = 1'b1;
          state_d  = imem.imem_gnt ? S_DROP : S_REQ;
        end else if (imem.imem_gnt) begin
          req_pc_d = fpc_q;
          fpc_d    = fpc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        if (pc_src_e_i) begin
          fpc_d    = redirectPc;
          bufClear = 1'b1;
          state_d  = imem.imem_rvalid ? S_REQ : S_DROP;
        end else if (imem.imem_rvalid) begin
          outValid = 1'b1;
          outInstr = imem.imem_rdata;
          outPc    = req_pc_q;
          if (stall_f_i) begin
            bufLoad = 1'b1;
            state_d = S_FULL;
          end else begin
            state_d = S_REQ;
          end
        end
      end

      S_FULL: begin
        if (pc_src_e_i) begin
          fpc_d    = redirectPc;
          bufClear = 1'b1;
          state_d  = S_REQ;
        end else begin
          outValid = bufValid;
          outInstr = bufInstr;
          outPc    = bufPc;
          if (!stall_f_i) begin
            bufClear = 1'b1;
            state_d  = S_REQ;
          end
        end
      end

      S_DROP: begin
        // The stale response still has to drain, so a further redirect only
        // retargets the PC; the state leaves on the response either way.
        if (pc_src_e_i) begin
          fpc_d    = redirectPc;
          bufClear = 1'b1;
        end
        if (imem.imem_rvalid) begin
          state_d = S_REQ;
        end
      end

      default: state_d = S_REQ;
    endcase
  end

  // Memory request drive and bypass/buffer/NOP output mux
  always_comb begin
    imem.imem_req  = memReq;
    imem.imem_addr = fpc_q;
    fetch_valid_o  = outValid;
    rd_f_o         = outValid ? outInstr : NOP_INSTR;
    pc_f_o         = outValid ? outPc : 32'h0;
    pc_plus4_f_o   = outValid ? (outPc + 32'd4) : 32'h0;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations plus a randomized run against a transaction-level model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_f_i;
  logic        pc_src_e_i;
  logic [31:0] pc_target_e_i;
  logic [31:0] rd_f_o;
  logic [31:0] pc_f_o;
  logic [31:0] pc_plus4_f_o;
  logic        fetch_valid_o;

  fetch_if imem ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_f_i     (stall_f_i),
    .pc_src_e_i    (pc_src_e_i),
    .pc_target_e_i (pc_target_e_i),
    .imem          (imem.master),
    .rd_f_o        (rd_f_o),
    .pc_f_o        (pc_f_o),
    .pc_plus4_f_o  (pc_plus4_f_o),
    .fetch_valid_o (fetch_valid_o)
  );

  // Free-running clock
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Memory model state
  bit          memBusy;
  logic [31:0] memAddr;
  int          waitCnt, rvCnt, gntDelay, rvDelay;
  bit          randMem;

  // Transaction-level reference: next address to ask for, what is in flight,
  // and what instruction is waiting to be taken by decode.
  bit          mOut, mStale, mHeld;
  logic [31:0] mOutPc, mHeldPc, mHeldInstr, mReqAddr;

  // Values sampled from the DUT in the last checked cycle
  logic        sReq, sValid;
  logic [31:0] sAddr, sRd, sPc, sPc4;
  int          deliveredCnt;

  // Instruction memory contents
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    if (a == 32'h8) return 32'hDEAD_BEEF;
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  // Single comparison with failure report
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive execute/hazard inputs and the memory responder for this cycle
  task automatic applyStimulus(input bit stall, input bit redir, input logic [31:0] tgt);
    stall_f_i        = stall;
    pc_src_e_i       = redir;
    pc_target_e_i    = tgt;
    imem.imem_gnt    = imem.imem_req && !memBusy && (waitCnt >= gntDelay);
    imem.imem_rvalid = memBusy && (rvCnt == 1);
    imem.imem_rdata  = imem.imem_rvalid ? memWord(memAddr) : $urandom();
  endtask

  // Compare all outputs against the model, then advance model and memory
  task automatic checkOutput();
    bit          expReq, eValid, g, rv;
    logic [31:0] ePc, eRd;
    sReq   = imem.imem_req;
    sAddr  = imem.imem_addr;
    sValid = fetch_valid_o;
    sRd    = rd_f_o;
    sPc    = pc_f_o;
    sPc4   = pc_plus4_f_o;
    g      = imem.imem_gnt;
    rv     = imem.imem_rvalid;

    expReq = !mOut && !mHeld;
    eValid = 1'b0;
    ePc    = 32'h0;
    eRd    = NOP_INSTR;
    if (!pc_src_e_i) begin
      if (mHeld) begin
        eValid = 1'b1; ePc = mHeldPc; eRd = mHeldInstr;
      end else if (mOut && rv && !mStale) begin
        eValid = 1'b1; ePc = mOutPc; eRd = memWord(mOutPc);
      end
    end
    chk("req", {31'b0, sReq}, {31'b0, expReq});
    if (expReq) chk("addr", sAddr, mReqAddr);
    chk("valid", {31'b0, sValid}, {31'b0, eValid});
    chk("rd", sRd, eRd);
    chk("pc", sPc, eValid ? ePc : 32'h0);
    chk("pc4", sPc4, eValid ? ePc + 32'd4 : 32'h0);
    if (sValid && !stall_f_i) deliveredCnt++;

    if (mHeld && (pc_src_e_i || !stall_f_i)) mHeld = 1'b0;
    if (mOut && rv) begin
      mOut = 1'b0;
      if (!mStale && !pc_src_e_i && stall_f_i) begin
        mHeld = 1'b1; mHeldPc = mOutPc; mHeldInstr = memWord(mOutPc);
      end
    end
    if (expReq && g) begin
      mOut = 1'b1; mOutPc = mReqAddr; mStale = 1'b0; mReqAddr = mReqAddr + 32'd4;
    end
    if (pc_src_e_i) begin
      mReqAddr = pc_target_e_i & 32'hFFFF_FFFC;
      if (mOut) mStale = 1'b1;
    end

    if (rv) memBusy = 1'b0;
    else if (memBusy) rvCnt--;
    if (g) begin
      if (randMem) begin
        gntDelay = $urandom_range(0, 3);
        rvDelay  = $urandom_range(1, 4);
      end
      memBusy = 1'b1; memAddr = imem.imem_addr; rvCnt = rvDelay; waitCnt = 0;
    end else if (imem.imem_req && !memBusy) begin
      waitCnt++;
    end
  endtask

  task automatic runCycle(input bit stall, input bit redir, input logic [31:0] tgt);
    applyStimulus(stall, redir, tgt);
    @(negedge clk_i);
    checkOutput();
    @(posedge clk_i);
    #1;
  endtask

  task automatic resetState();
    memBusy = 1'b0; waitCnt = 0; rvCnt = 0;
    mOut = 1'b0; mStale = 1'b0; mHeld = 1'b0; mReqAddr = 32'h0;
    stall_f_i = 1'b0; pc_src_e_i = 1'b0; pc_target_e_i = 32'h0;
    imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'h0;
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_req"}, {31'b0, imem.imem_req}, 32'd1);
    chk({tag, "_addr"}, imem.imem_addr, 32'h0);
    chk({tag, "_valid"}, {31'b0, fetch_valid_o}, 32'd0);
    chk({tag, "_rd"}, rd_f_o, 32'h0000_0013);
    chk({tag, "_pc"}, pc_f_o, 32'h0);
    chk({tag, "_pc4"}, pc_plus4_f_o, 32'h0);
  endtask

  initial begin
    randMem = 1'b0; gntDelay = 0; rvDelay = 1; deliveredCnt = 0;
    resetState();
    rst_i = 1'b1;
    #1;
    checkResetOutputs("reset");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Zero-wait memory, no stall: pc 0 then 4, bubbles in between
    runCycle(0, 0, 0);
    chk("t1_req0", {31'b0, sReq}, 32'd1); chk("t1_addr0", sAddr, 32'h0);
    chk("t1_bubble0", {31'b0, sValid}, 32'd0);
    runCycle(0, 0, 0);
    chk("t1_valid0", {31'b0, sValid}, 32'd1); chk("t1_rd0", sRd, 32'h0050_0093);
    chk("t1_pc0", sPc, 32'h0); chk("t1_pc4_0", sPc4, 32'h4);
    runCycle(0, 0, 0);
    chk("t1_bubble1", sRd, 32'h0000_0013); chk("t1_addr4", sAddr, 32'h4);
    runCycle(0, 0, 0);
    chk("t1_rd4", sRd, 32'h0010_0113); chk("t1_pc4", sPc, 32'h4);

    // Stall held for three cycles while the pc 8 instruction arrives
    runCycle(0, 0, 0);
    chk("t2_addr8", sAddr, 32'h8);
    for (int i = 0; i < 3; i++) begin
      runCycle(1, 0, 0);
      chk("t2_rd", sRd, 32'hDEAD_BEEF); chk("t2_pc", sPc, 32'h8);
      chk("t2_pc4", sPc4, 32'hC); chk("t2_valid", {31'b0, sValid}, 32'd1);
      if (i > 0) chk("t2_noreq", {31'b0, sReq}, 32'd0);
    end
    runCycle(0, 0, 0);
    chk("t2_release", sPc, 32'h8);
    runCycle(0, 0, 0);
    chk("t2_req12", {31'b0, sReq}, 32'd1); chk("t2_addr12", sAddr, 32'hC);

    // Redirect to 0x100 in the same cycle the 0x10 request is granted
    runCycle(0, 0, 0);
    chk("t3_pc12", sPc, 32'hC);
    runCycle(0, 1, 32'h100);
    chk("t3_addr10", sAddr, 32'h10); chk("t3_noval", {31'b0, sValid}, 32'd0);
    runCycle(0, 0, 0);
    chk("t3_stale", {31'b0, sValid}, 32'd0);
    runCycle(0, 0, 0);
    chk("t3_req100", sAddr, 32'h100);

    // Redirect to 0x203 while the buffer is full
    runCycle(1, 0, 0);
    chk("t4_bypass", sPc, 32'h100);
    runCycle(1, 1, 32'h203);
    chk("t4_kill", {31'b0, sValid}, 32'd0);

    // Grant delayed 4 cycles, response 3 cycles after grant
    gntDelay = 4; rvDelay = 3; deliveredCnt = 0;
    for (int i = 0; i < 8; i++) begin
      runCycle(0, 0, 0);
      if (i < 5) begin
        chk("t5_req", {31'b0, sReq}, 32'd1); chk("t5_addr", sAddr, 32'h200);
      end
    end
    chk("t5_pc", sPc, 32'h200);
    chk("t5_count", deliveredCnt, 32'd1);
    gntDelay = 0; rvDelay = 1;

    // Wrap-around at the top of the address space
    runCycle(0, 1, 32'hFFFF_FFFC);
    runCycle(0, 0, 0);
    runCycle(0, 0, 0);
    chk("t6_addrTop", sAddr, 32'hFFFF_FFFC);
    runCycle(0, 0, 0);
    chk("t6_pcTop", sPc, 32'hFFFF_FFFC); chk("t6_pc4wrap", sPc4, 32'h0);
    rvDelay = 3;
    runCycle(0, 0, 0);
    chk("t6_addrWrap", sAddr, 32'h0);

    // Reset while waiting for a response
    rst_i = 1'b1;
    resetState();
    #1;
    checkResetOutputs("midreset");
    @(negedge clk_i);
    rst_i = 1'b0;
    rvDelay = 1;
    @(posedge clk_i);
    #1;
    runCycle(0, 0, 0);
    chk("t7_addr", sAddr, 32'h0);
    runCycle(0, 0, 0);
    chk("t7_rd", sRd, 32'h0050_0093);

    // Randomized traffic against the model
    randMem = 1'b1; deliveredCnt = 0;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom();
      runCycle($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 7, tgt);
    end
    chk("liveness", {31'b0, deliveredCnt > 100}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
